// File: rtl/ser_parity_tx_pkg.sv
// ============================================================================
// Module   : ser_parity_tx_pkg
// Purpose  : Shared state encodings, serial line levels and sizing helper for
//            the serial frame transmitter (and its receive-side counterpart).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ser_parity_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser_parity_tx_if.sv
// ============================================================================
// Module   : ser_parity_tx_if
// Purpose  : Word handshake and serial status bundle between a byte producer
//            (master) and the frame transmitter (slave).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ser_parity_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              o_txd;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_txd,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_txd,
        output o_busy,
        output o_done
    );
endinterface

`default_nettype wire

// File: rtl/parity_gen.sv
// ============================================================================
// Module   : parity_gen (+ _xor2 gate)
// Purpose  : DATA_W-wide XOR reduction chain built from 2-input XOR gates.
//            Only built when SER_TX_PARITY_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef SER_TX_PARITY_EN
module parity_gen #(
    parameter int DATA_W = 8
) (
    input  wire logic [DATA_W-1:0] data,
    output logic                   parity
);
    logic [DATA_W-1:0] w_chain;

    assign w_chain[0] = data[0];

    generate
        if (DATA_W > 1) begin : g_chain
            for (genvar i = 1; i < DATA_W; i++) begin : g_xor
                _xor2 u_xor (
                    .a (w_chain[i-1]),
                    .b (data[i]),
                    .y (w_chain[i])
                );
            end
        end
    endgenerate

    assign parity = w_chain[DATA_W-1];
endmodule

module _xor2 (
    input  wire logic a,
    input  wire logic b,
    output logic      y
);
    assign y = a ^ b;
endmodule
`endif

`default_nettype wire

// File: rtl/ser_parity_tx.sv
// ============================================================================
// Module   : ser_parity_tx
// Purpose  : Serial frame transmitter: start bit, DATA_W data bits LSB first,
//            optional parity bit (macro SER_TX_PARITY_EN), stop bit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ser_parity_tx
    import ser_parity_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 4,
    parameter int PARITY_ODD = 0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    ser_parity_tx_if.slave   bus
);
    localparam int c_baud_w = cnt_w(BAUD_DIV);
    localparam int c_bit_w  = cnt_w(DATA_W);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(BAUD_DIV - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_W - 1);

    tx_state_t           r_state;
    logic [c_baud_w-1:0] r_baud_cnt;
    logic [c_bit_w-1:0]  r_bit_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_txd;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_bit_end;
    logic [DATA_W-1:0]   w_shift_next;

    assign w_bit_end    = (r_baud_cnt == c_baud_last);
    assign w_shift_next = r_shift >> 1;

`ifdef SER_TX_PARITY_EN
    logic r_parity;
    logic w_xor_all;
    logic w_parity;

    parity_gen #(
        .DATA_W (DATA_W)
    ) u_parity_gen (
        .data   (bus.i_data),
        .parity (w_xor_all)
    );

    assign w_parity = w_xor_all ^ (PARITY_ODD != 0);
`else
    localparam bit c_unused_parity_odd = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= LINE_IDLE;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef SER_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            // Every non-idle state ticks the baud counter; boundaries wrap it.
            if (r_state != IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.i_valid && r_ready) begin
                        r_shift    <= bus.i_data;
`ifdef SER_TX_PARITY_EN
                        r_parity   <= w_parity;
`endif
                        r_state    <= START;
                        r_txd      <= START_BIT;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_txd   <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift <= w_shift_next;
                        if (r_bit_idx == c_bit_last) begin
                            r_bit_idx <= '0;
`ifdef SER_TX_PARITY_EN
                            r_state   <= PARITY;
                            r_txd     <= r_parity;
`else
                            r_state   <= STOP;
                            r_txd     <= STOP_BIT;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_txd     <= w_shift_next[0];
                        end
                    end
                end
`ifdef SER_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_txd   <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_state <= IDLE;
                        r_txd   <= LINE_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_txd      <= LINE_IDLE;
                    r_ready    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_baud_cnt <= '0;
                    r_bit_idx  <= '0;
                end
            endcase
        end
    end

    assign bus.o_txd   = r_txd;
    assign bus.o_ready = r_ready;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ser_parity_tx.sv
// ============================================================================
// Module   : tb_ser_parity_tx
// Purpose  : Self-checking bench for ser_parity_tx: frame-level model plus
//            directed vectors on two configurations (BAUD_DIV 4/even, 1/odd).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ser_parity_tx;
    localparam int DW   = 8;
    localparam int B0   = 4;
    localparam int B1   = 1;
    localparam int ODD0 = 0;
    localparam int ODD1 = 1;
`ifdef SER_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = DW + 2 + P;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ser_parity_tx_if #(.DATA_W(DW)) bus0 ();
    ser_parity_tx_if #(.DATA_W(DW)) bus1 ();

    ser_parity_tx #(.DATA_W(DW), .BAUD_DIV(B0), .PARITY_ODD(ODD0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    ser_parity_tx #(.DATA_W(DW), .BAUD_DIV(B1), .PARITY_ODD(ODD1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    logic       txd_s [2];
    logic       rdy_s [2];
    logic       busy_s[2];
    logic       done_s[2];
    logic       vld_s [2];
    logic [7:0] dat_s [2];

    assign txd_s[0]  = bus0.o_txd;   assign txd_s[1]  = bus1.o_txd;
    assign rdy_s[0]  = bus0.o_ready; assign rdy_s[1]  = bus1.o_ready;
    assign busy_s[0] = bus0.o_busy;  assign busy_s[1] = bus1.o_busy;
    assign done_s[0] = bus0.o_done;  assign done_s[1] = bus1.o_done;
    assign vld_s[0]  = bus0.i_valid; assign vld_s[1]  = bus1.i_valid;
    assign dat_s[0]  = bus0.i_data;  assign dat_s[1]  = bus1.i_data;

    task automatic chk(input string nm, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual %b required %b at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual %h required %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: the expected line level for every remaining cycle of the frame.
    bit   exp_q [2][$];
    bit   done_f[2];
    bit   m_idle;
    logic m_txd;

    function automatic void push_frame(input int k, input logic [7:0] d);
        int baud = (k == 0) ? B0 : B1;
        int odd  = (k == 0) ? ODD0 : ODD1;
        bit fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < DW; i++) fb.push_back(d[i]);
        if (P == 1) fb.push_back(bit'(($countones(d) % 2) ^ odd));
        fb.push_back(1'b1);
        foreach (fb[i]) begin
            for (int c = 0; c < baud; c++) exp_q[k].push_back(fb[i]);
        end
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                exp_q[k].delete();
                done_f[k] = 1'b0;
                chk("rst_txd",  k, txd_s[k],  1'b1);
                chk("rst_rdy",  k, rdy_s[k],  1'b1);
                chk("rst_busy", k, busy_s[k], 1'b0);
                chk("rst_done", k, done_s[k], 1'b0);
            end else begin
                m_idle = (exp_q[k].size() == 0);
                m_txd  = m_idle ? 1'b1 : exp_q[k][0];
                chk("txd",  k, txd_s[k],  m_txd);
                chk("rdy",  k, rdy_s[k],  m_idle);
                chk("busy", k, busy_s[k], !m_idle);
                chk("done", k, done_s[k], done_f[k]);
                if (!m_idle) void'(exp_q[k].pop_front());
                done_f[k] = !m_idle && (exp_q[k].size() == 0);
                if (m_idle && vld_s[k]) push_frame(k, dat_s[k]);
            end
        end
    end

    task automatic drive(input int k, input logic v, input logic [7:0] d);
        if (k == 0) begin bus0.i_valid = v; bus0.i_data = d; end
        else        begin bus1.i_valid = v; bus1.i_data = d; end
    endtask

    // Wait (bounded) for a negedge with ready high; acceptance is the next posedge.
    task automatic wait_ready(input int k, input string nm, output int cyc);
        bit ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy_s[k] === 1'b1) begin ok = 1'b1; break; end
            cyc++;
        end
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d timeout waiting for ready", nm, k);
        end
    endtask

    task automatic send(input int k, input logic [7:0] d);
        int cyc;
        @(posedge clk); #1;
        drive(k, 1'b1, d);
        wait_ready(k, "send", cyc);
        @(posedge clk); #1;
        drive(k, 1'b0, 8'h00);
    endtask

    // Sample the first cycle of each bit; count any done pulses within the frame.
    task automatic capture(input int k, input int baud, output logic [15:0] bits, output int dn);
        bits = '0;
        dn   = 0;
        for (int j = 0; j < NB; j++) begin
            for (int c = 0; c < baud; c++) begin
                @(negedge clk);
                if (c == 0) bits[j] = txd_s[k];
                if (done_s[k] === 1'b1) dn++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        logic [15:0] exp;
        int          dn;
        int          cyc;

        reset = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk("init_txd", k, txd_s[k], 1'b1);
            chk("init_rdy", k, rdy_s[k], 1'b1);
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // 0xA5 on the BAUD_DIV=4 even-parity instance
        send(0, 8'hA5);
        capture(0, B0, bits, dn);
`ifdef SER_TX_PARITY_EN
        exp = {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
`else
        exp = {6'b0, 1'b1, 8'hA5, 1'b0};
`endif
        chk16("a5_bits", 0, bits, exp);
        chk16("a5_no_early_done", 0, 16'(dn), 16'd0);
        @(negedge clk);
        chk("a5_done", 0, done_s[0], 1'b1);

        // 0x07 with odd parity (bit 0), then even parity (bit 1)
        send(1, 8'h07);
        capture(1, B1, bits, dn);
`ifdef SER_TX_PARITY_EN
        exp = {5'b0, 1'b1, 1'b0, 8'h07, 1'b0};
`else
        exp = {6'b0, 1'b1, 8'h07, 1'b0};
`endif
        chk16("07_odd_bits", 1, bits, exp);
        @(negedge clk);
        send(0, 8'h07);
        capture(0, B0, bits, dn);
`ifdef SER_TX_PARITY_EN
        exp = {5'b0, 1'b1, 1'b1, 8'h07, 1'b0};
`else
        exp = {6'b0, 1'b1, 8'h07, 1'b0};
`endif
        chk16("07_even_bits", 0, bits, exp);
        @(negedge clk);

        // 0xFF at one cycle per bit
        send(1, 8'hFF);
        capture(1, B1, bits, dn);
`ifdef SER_TX_PARITY_EN
        exp = {5'b0, 1'b1, 1'b1, 8'hFF, 1'b0};
`else
        exp = {6'b0, 1'b1, 8'hFF, 1'b0};
`endif
        chk16("ff_bits", 1, bits, exp);
        chk16("ff_no_early_done", 1, 16'(dn), 16'd0);
        @(negedge clk);
        chk("ff_done", 1, done_s[1], 1'b1);

        // Valid held high: second word only taken in the done cycle
        @(posedge clk); #1;
        drive(0, 1'b1, 8'h3C);
        wait_ready(0, "b2b_first", cyc);
        @(posedge clk); #1;
        drive(0, 1'b1, 8'hC3);
        wait_ready(0, "b2b_gap", cyc);
`ifdef SER_TX_PARITY_EN
        chk16("b2b_len", 0, 16'(cyc), 16'd44);
`else
        chk16("b2b_len", 0, 16'(cyc), 16'd40);
`endif
        chk("b2b_gap_done", 0, done_s[0], 1'b1);
        chk("b2b_gap_txd",  0, txd_s[0],  1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00);
        @(negedge clk);
        chk("b2b_start_txd",  0, txd_s[0],  1'b0);
        chk("b2b_start_busy", 0, busy_s[0], 1'b1);
        wait_ready(0, "b2b_second", cyc);
        chk("b2b_second_done", 0, done_s[0], 1'b1);

        // Reset during the data bits of 0x55
        send(0, 8'h55);
        repeat (12) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_txd",  0, txd_s[0],  1'b1);
        chk("midrst_rdy",  0, rdy_s[0],  1'b1);
        chk("midrst_busy", 0, busy_s[0], 1'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_s[0] === 1'b1) dn++;
        end
        chk16("midrst_no_done", 0, 16'(dn), 16'd0);

        send(0, 8'h12);
        capture(0, B0, bits, dn);
`ifdef SER_TX_PARITY_EN
        exp = {5'b0, 1'b1, 1'b0, 8'h12, 1'b0};
`else
        exp = {6'b0, 1'b1, 8'h12, 1'b0};
`endif
        chk16("12_bits", 0, bits, exp);
        @(negedge clk);
        chk("12_done", 0, done_s[0], 1'b1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
